// File: rtl/spell_dbg_pkg.sv
// Shared types and constants for the SPELL debug-port sequencer.
package spell_dbg_pkg;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_WRITE = 3'd1,
        CMD_READ  = 3'd2,
        CMD_STEP  = 3'd3,
        CMD_RUN   = 3'd4,
        CMD_HALT  = 3'd5
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_W,
        ST_LOAD,
        ST_DUMP,
        ST_SHIFT_R,
        ST_STEP_PULSE,
        ST_WAIT_STOP,
        ST_RESP
    } state_t;

    localparam logic [1:0] SEL_PC     = 2'd0;
    localparam logic [1:0] SEL_SP     = 2'd1;
    localparam logic [1:0] SEL_OPCODE = 2'd2;
    localparam logic [1:0] SEL_TOS    = 2'd3;

    localparam int WORD_W = 8;

endpackage

// File: rtl/spell_dbg_shifter.sv
// 8-bit MSB-first serializer/deserializer for the CPU debug register.
import spell_dbg_pkg::*;

module spell_dbg_shifter (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_tx,
    input  logic              start_rx,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              sdi,
    output logic              sdo,
    output logic              done,
    output logic [WORD_W-1:0] rx_word
);

    logic              tx_q, tx_d;
    logic              rx_q, rx_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [2:0]        cnt_q, cnt_d;

    always_comb begin
        tx_d    = tx_q;
        rx_d    = rx_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (start_tx) begin
            tx_d    = 1'b1;
            rx_d    = 1'b0;
            shreg_d = tx_data;
            cnt_d   = 3'd0;
        end else if (start_rx) begin
            tx_d  = 1'b0;
            rx_d  = 1'b1;
            cnt_d = 3'd0;
        end else if (tx_q || rx_q) begin
            // tx shifts zeros in behind the data; rx captures the CPU's MSB
            shreg_d = {shreg_q[WORD_W-2:0], rx_q & sdi};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                tx_d = 1'b0;
                rx_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q    <= 1'b0;
            rx_q    <= 1'b0;
            shreg_q <= '0;
            cnt_q   <= 3'd0;
        end else begin
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sdo     = tx_q & shreg_q[WORD_W-1];
    assign done    = (tx_q || rx_q) && (cnt_q == 3'd7);
    // Includes the bit being sampled this cycle, so it is complete when done is high.
    assign rx_word = {shreg_q[WORD_W-2:0], sdi};

endmodule

// File: rtl/spell_dbg_ctrl.sv
// Host-side sequencer turning register/step/run/halt commands into the
// SPELL CPU bit-serial load/dump protocol and run/step control lines.
import spell_dbg_pkg::*;

module spell_dbg_ctrl #(
    parameter int STEP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_cmd,
    input  logic [1:0]  req_sel,
    input  logic [7:0]  req_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic        cpu_run,
    output logic        cpu_step,
    output logic        cpu_load,
    output logic        cpu_dump,
    output logic        cpu_shift_in,
    output logic [1:0]  cpu_reg_sel,
    input  logic        cpu_sleep,
    input  logic        cpu_stop,
    input  logic        cpu_wait_delay,
    input  logic        cpu_shift_out
);

    localparam logic [15:0] TO_LAST = 16'(STEP_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        run_q, run_d;
    logic        err_q, err_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic        rerr_q, rerr_d;
    logic        step_q, step_d;
    logic        load_q, load_d;
    logic        dump_q, dump_d;

    logic        start_tx, start_rx, sh_done;
    logic [7:0]  sh_word;
    logic        unused_wait_delay;

    assign unused_wait_delay = cpu_wait_delay;

    spell_dbg_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .start_tx (start_tx),
        .start_rx (start_rx),
        .tx_data  (req_data),
        .sdi      (cpu_shift_out),
        .sdo      (cpu_shift_in),
        .done     (sh_done),
        .rx_word  (sh_word)
    );

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        err_d    = err_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        start_tx = 1'b0;
        start_rx = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    sel_d   = req_sel;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                    case (req_cmd)
                        CMD_NOP: ;
                        CMD_RUN: run_d = 1'b1;
                        CMD_WRITE: begin
                            if (run_q) err_d = 1'b1;
                            else begin
                                state_d  = ST_SHIFT_W;
                                start_tx = 1'b1;
                            end
                        end
                        CMD_READ: begin
                            if (run_q) err_d = 1'b1;
                            else state_d = ST_DUMP;
                        end
                        CMD_STEP: begin
                            if (run_q) err_d = 1'b1;
                            else state_d = ST_STEP_PULSE;
                        end
                        CMD_HALT: begin
                            run_d   = 1'b0;
                            cnt_d   = '0;
                            state_d = ST_WAIT_STOP;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_SHIFT_W: if (sh_done) state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_RESP;
            ST_DUMP: begin
                start_rx = 1'b1;
                state_d  = ST_SHIFT_R;
            end
            ST_SHIFT_R: begin
                if (sh_done) begin
                    rdata_d = sh_word;
                    state_d = ST_RESP;
                end
            end
            ST_STEP_PULSE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_STOP;
            end
            ST_WAIT_STOP: begin
                // A stop seen on the final counted cycle still wins over the timeout.
                if (cpu_stop || cpu_sleep) begin
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_RESP);
        rerr_d  = (state_d == ST_RESP) && err_d;
        step_d  = (state_d == ST_STEP_PULSE);
        load_d  = (state_d == ST_LOAD);
        dump_d  = (state_d == ST_DUMP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= SEL_PC;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rerr_q  <= 1'b0;
            step_q  <= 1'b0;
            load_q  <= 1'b0;
            dump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            rerr_q  <= rerr_d;
            step_q  <= step_d;
            load_q  <= load_d;
            dump_q  <= dump_d;
        end
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = valid_q;
    assign rsp_data    = rdata_q;
    assign rsp_err     = rerr_q;
    assign cpu_run     = run_q;
    assign cpu_step    = step_q;
    assign cpu_load    = load_q;
    assign cpu_dump    = dump_q;
    assign cpu_reg_sel = sel_q;

endmodule

// File: tb/tb_spell_dbg_ctrl.sv
// Scoreboard bench for spell_dbg_ctrl with a bit-serial CPU debug-port model.
module tb_spell_dbg_ctrl;
    import spell_dbg_pkg::*;

    localparam int TO    = 16;
    localparam int NEVER = 32'h3fffffff;

    logic       clk = 1'b0, rst = 1'b1;
    logic       req_valid = 1'b0, req_ready;
    logic [2:0] req_cmd = 3'd0;
    logic [1:0] req_sel = 2'd0;
    logic [7:0] req_data = 8'd0;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_data;
    logic       cpu_run, cpu_step, cpu_load, cpu_dump, cpu_shift_in;
    logic [1:0] cpu_reg_sel;
    logic       cpu_sleep, cpu_stop, cpu_shift_out;
    logic       cpu_wait_delay = 1'b0;

    spell_dbg_ctrl #(.STEP_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_sel(req_sel), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cpu_run(cpu_run), .cpu_step(cpu_step), .cpu_load(cpu_load), .cpu_dump(cpu_dump),
        .cpu_shift_in(cpu_shift_in), .cpu_reg_sel(cpu_reg_sel),
        .cpu_sleep(cpu_sleep), .cpu_stop(cpu_stop), .cpu_wait_delay(cpu_wait_delay),
        .cpu_shift_out(cpu_shift_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // CPU debug-port model: shift when neither load nor dump is asserted.
    logic       cpu_init = 1'b1;
    logic [7:0] dbg_r = 8'h00;
    logic [7:0] cregs [4];
    always @(posedge clk) begin
        if (cpu_init) begin
            cregs[0] <= 8'h12; cregs[1] <= 8'h34; cregs[2] <= 8'h56; cregs[3] <= 8'h3C;
        end else if (cpu_load) cregs[cpu_reg_sel] <= dbg_r;
        if (cpu_dump) dbg_r <= cregs[cpu_reg_sel];
        else if (!cpu_load) dbg_r <= {dbg_r[6:0], cpu_shift_in};
    end
    assign cpu_shift_out = dbg_r[7];

    int   stop_at = NEVER;
    logic use_sleep = 1'b0;
    assign cpu_stop  = !use_sleep && (cyc >= stop_at);
    assign cpu_sleep =  use_sleep && (cyc >= stop_at);

    typedef struct {
        int         acc;
        logic [2:0] cmd;
        logic [1:0] sel;
        logic [7:0] data;
        logic       err;
        logic [7:0] rdata;
        int         lat;
        logic       run;
        logic       stepped;
    } exp_t;
    typedef struct { int kind; int val; } chk_t;

    exp_t exp_q[$];
    chk_t chk_q[$];

    // Reference state, advanced at command accept.
    logic       ref_run = 1'b0;
    logic [7:0] ref_rdata = 8'h00;
    logic [7:0] ref_regs [4];
    int         ref_loads = 0;

    int checks = 0, errors = 0;
    int loads_seen = 0, act_cnt = 0;
    int load_cyc = -100, dump_cyc = -100, step_cyc = -100;
    logic [1:0] load_sel = 2'd0, dump_sel = 2'd0;
    exp_t m_e;
    chk_t m_k;

    task automatic cmp(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_load) begin loads_seen++; load_cyc = cyc; load_sel = cpu_reg_sel; end
        if (cpu_dump) begin dump_cyc = cyc; dump_sel = cpu_reg_sel; end
        if (cpu_step) step_cyc = cyc;
        if (cpu_load || cpu_dump || cpu_step || cpu_shift_in) act_cnt++;
        if (chk_q.size() > 0) begin
            m_k = chk_q.pop_front();
            case (m_k.kind)
                0: cmp("reset_outputs", int'({req_ready, rsp_valid, rsp_data, rsp_err, cpu_run,
                        cpu_step, cpu_load, cpu_dump, cpu_shift_in, cpu_reg_sel}), 0);
                1: cmp("load_count", loads_seen, m_k.val);
                2: cmp("port_activity", act_cnt, m_k.val);
                4: cmp("ready_after_reset", int'(req_ready), m_k.val);
                default: begin
                    checks++; errors++;
                    $display("FAIL wait_bound waited=%0d cycles limit=200", m_k.val);
                end
            endcase
        end
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp data=%0d err=%0d exp=none", rsp_data, rsp_err);
            end else begin
                m_e = exp_q.pop_front();
                cmp("rsp_latency", cyc - m_e.acc, m_e.lat);
                cmp("rsp_err", int'(rsp_err), int'(m_e.err));
                cmp("rsp_data", int'(rsp_data), int'(m_e.rdata));
                cmp("cpu_run", int'(cpu_run), int'(m_e.run));
                if (m_e.cmd == CMD_WRITE && !m_e.err) begin
                    cmp("load_cycle", load_cyc - m_e.acc, 9);
                    cmp("load_sel", int'(load_sel), int'(m_e.sel));
                    cmp("cpu_reg_written", int'(cregs[m_e.sel]), int'(m_e.data));
                end
                if (m_e.cmd == CMD_READ && !m_e.err) begin
                    cmp("dump_cycle", dump_cyc - m_e.acc, 1);
                    cmp("dump_sel", int'(dump_sel), int'(m_e.sel));
                end
                if (m_e.stepped) cmp("step_cycle", step_cyc - m_e.acc, 1);
            end
        end
    end

    // Called at a negedge; returns at the negedge of cycle 1 with req_valid still high.
    task automatic issue(input logic [2:0] cmd, input logic [1:0] sel, input logic [7:0] d,
                         input int dly, input logic slp);
        exp_t e;
        int   w, st;
        req_valid = 1'b1; req_cmd = cmd; req_sel = sel; req_data = d;
        w = 0;
        while (!req_ready && w < 200) begin @(negedge clk); w++; end
        if (!req_ready) begin chk_q.push_back('{3, w}); return; end
        e.acc = cyc; e.cmd = cmd; e.sel = sel; e.data = d;
        e.err = 1'b0; e.lat = 1; e.stepped = 1'b0;
        st = 0;
        case (cmd)
            CMD_NOP: ;
            CMD_WRITE: if (ref_run) e.err = 1'b1;
                       else begin e.lat = 10; ref_regs[sel] = d; ref_loads++; end
            CMD_READ:  if (ref_run) e.err = 1'b1;
                       else begin e.lat = 10; ref_rdata = ref_regs[sel]; end
            CMD_STEP:  if (ref_run) e.err = 1'b1; else st = 2;
            CMD_RUN:   ref_run = 1'b1;
            CMD_HALT:  begin ref_run = 1'b0; st = 1; end
            default:   e.err = 1'b1;
        endcase
        if (st != 0) begin
            // Stop waiting window covers cycles acc+st .. acc+st+TO-1.
            use_sleep = slp;
            stop_at   = (dly < 0) ? NEVER : e.acc + st + dly;
            if (dly >= 0 && dly < TO) e.lat = st + dly + 1;
            else begin e.lat = st + TO; e.err = 1'b1; end
            e.stepped = (st == 2);
        end
        e.rdata = ref_rdata;
        e.run   = ref_run;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        int w;
        w = 0;
        req_valid = 1'b0;
        while (exp_q.size() != 0 && w < 200) begin @(negedge clk); w++; end
        if (exp_q.size() != 0) begin chk_q.push_back('{3, w}); exp_q.delete(); end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_q.push_back('{0, 0});
        exp_q.delete();
        ref_run = 1'b0; ref_rdata = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_q.push_back('{4, 1});
        @(negedge clk);
    endtask

    initial begin
        int         a, r, dly, w;
        logic [2:0] c;
        logic [7:0] old;
        ref_regs = '{8'h12, 8'h34, 8'h56, 8'h3C};
        repeat (3) @(negedge clk);
        cpu_init = 1'b0;
        do_reset();

        issue(CMD_WRITE, SEL_SP, 8'hA5, 0, 1'b0); drain();
        issue(CMD_READ, SEL_TOS, 8'h00, 0, 1'b0); drain();
        issue(CMD_WRITE, SEL_PC, 8'h00, 0, 1'b0);
        issue(CMD_READ, SEL_PC, 8'h00, 0, 1'b0); drain();

        issue(CMD_RUN, SEL_PC, 8'h00, 0, 1'b0); drain();
        a = act_cnt;
        issue(CMD_WRITE, SEL_OPCODE, 8'hFF, 0, 1'b0);
        issue(CMD_READ, SEL_OPCODE, 8'h00, 0, 1'b0);
        issue(CMD_STEP, SEL_PC, 8'h00, 0, 1'b0); drain();
        chk_q.push_back('{2, a});
        issue(CMD_HALT, SEL_PC, 8'h00, 5, 1'b0); drain();

        issue(CMD_STEP, SEL_PC, 8'h00, 3, 1'b0);
        issue(CMD_STEP, SEL_PC, 8'h00, -1, 1'b0);
        issue(CMD_STEP, SEL_PC, 8'h00, TO - 1, 1'b1);
        issue(CMD_HALT, SEL_PC, 8'h00, 0, 1'b1); drain();

        a = act_cnt;
        issue(3'd7, SEL_SP, 8'hFF, 0, 1'b0);
        issue(3'd6, SEL_TOS, 8'hFF, 0, 1'b0); drain();
        chk_q.push_back('{2, a});

        // Commands queued back to back with req_valid held high throughout.
        issue(CMD_READ, SEL_SP, 8'h00, 0, 1'b0);
        issue(CMD_READ, SEL_OPCODE, 8'h00, 0, 1'b0);
        issue(CMD_NOP, SEL_PC, 8'h00, 0, 1'b0);
        issue(CMD_WRITE, SEL_TOS, 8'h5A, 0, 1'b0); drain();

        // Reset during cycle 5 of a WRITE.
        old = ref_regs[2];
        issue(CMD_WRITE, SEL_OPCODE, 8'hE7, 0, 1'b0);
        repeat (4) @(negedge clk);
        do_reset();
        ref_regs[2] = old;
        ref_loads--;
        repeat (12) @(negedge clk);
        chk_q.push_back('{1, ref_loads});
        issue(CMD_READ, SEL_OPCODE, 8'h00, 0, 1'b0); drain();

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 15);
            if (r < 4)       c = CMD_WRITE;
            else if (r < 8)  c = CMD_READ;
            else if (r < 10) c = CMD_STEP;
            else if (r < 11) c = CMD_RUN;
            else if (r < 13) c = CMD_HALT;
            else if (r < 14) c = CMD_NOP;
            else             c = 3'(r - 8);
            dly = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 20);
            issue(c, 2'($urandom_range(0, 3)), 8'($urandom), dly, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();
        chk_q.push_back('{1, ref_loads});
        w = 0;
        while (chk_q.size() != 0 && w < 50) begin @(negedge clk); w++; end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spell_dbg_ctrl.md
# spell_dbg_ctrl

Host-side sequencer for the SPELL CPU debug port. It turns single-word register read/write, step, run and halt commands from a host requester into the CPU's bit-serial load/dump protocol and its run/step control lines. It sits between the chip-level host logic and the CPU core, and is the only driver of the core's `run`, `step`, `load`, `dump`, `shift_in` and `reg_sel` inputs.

## Interface
- `STEP_TIMEOUT`, 255: maximum number of cycles to wait for `cpu_stop` after a STEP or HALT. Range 1–65535.
- `clk` in 1: clock. Everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1 / `req_ready` out 1: command handshake. Transfer happens when both are high.
- `req_cmd` in 3: 0 NOP, 1 WRITE, 2 READ, 3 STEP, 4 RUN, 5 HALT; 6–7 are illegal.
- `req_sel` in 2: register select. 0 PC, 1 SP, 2 opcode, 3 stack top.
- `req_data` in 8: WRITE data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out 8: READ result. Held until the next `rsp_valid`.
- `rsp_err` out 1: valid only with `rsp_valid`.
- `cpu_run`, `cpu_step`, `cpu_load`, `cpu_dump`, `cpu_shift_in` out 1; `cpu_reg_sel` out 2: CPU debug controls.
- `cpu_sleep`, `cpu_stop`, `cpu_wait_delay`, `cpu_shift_out` in 1: CPU status and serial data.

## Operation
CPU port contract:
- The CPU shifts its 8-bit debug register left on every edge where `cpu_load` and `cpu_dump` are both 0. The shifted-in bit is `cpu_shift_in`.
- `cpu_shift_out` is combinationally equal to bit 7 of that register.
- `cpu_load=1` copies the register into the selected CPU register.
- `cpu_dump=1` copies the selected CPU register into it.

States: IDLE, SHIFT_W, LOAD, DUMP, SHIFT_R, STEP_PULSE, WAIT_STOP, RESP.
- **IDLE**
  - `req_ready=1`.
  - `cpu_reg_sel` is latched from `req_sel` on accept.
  - Accepting NOP, or RUN: RUN sets the `run_q` register. Go to RESP with err=0.
  - Accepting an illegal opcode: go to RESP with err=1. No port activity.
- **WRITE / READ**
  - If `run_q=1`, go straight to RESP with err=1. No port activity.
  - Otherwise a WRITE goes to SHIFT_W. A READ goes to DUMP.
- **SHIFT_W**: 8 cycles driving `cpu_shift_in` with `req_data[7]` down to `[0]`, MSB first. Then LOAD.
- **LOAD**: `cpu_load=1` for exactly 1 cycle. Then RESP with err=0.
- **DUMP**: `cpu_dump=1` for exactly 1 cycle. Then SHIFT_R.
- **SHIFT_R**
  - 8 cycles with `cpu_shift_in=0`.
  - Sample `cpu_shift_out` each cycle into the LSB of the capture register, which shifts left, so the first sample becomes bit 7.
  - Then RESP: `rsp_data` = the captured word, err=0.
- **STEP**
  - If `run_q=1`: RESP with err=1.
  - Otherwise STEP_PULSE: `cpu_step=1` for 1 cycle. Then WAIT_STOP.
- **HALT**: clear `run_q`, then WAIT_STOP.
- **WAIT_STOP**
  - Count cycles. Exit when `cpu_stop | cpu_sleep` is sampled high, giving RESP with err=0.
  - If the count reaches `STEP_TIMEOUT` first, RESP with err=1.
  - Stop has priority over the timeout when both occur on the same cycle.
- **RESP**: `rsp_valid=1` for 1 cycle, then IDLE.
- Other outputs:
  - `cpu_run = run_q` at all times.
  - `cpu_wait_delay` is status only. It does not affect sequencing.
- `rsp_data` changes only on a successful READ. Failed commands leave it unchanged.

## Timing
- Reset values:
  - All outputs 0: `req_ready`, `rsp_valid`, `rsp_data=8'h00`, `rsp_err`, all `cpu_*` outputs, `cpu_reg_sel=2'b00`.
  - `run_q=0`.
  - State IDLE, counters 0.
  - `req_ready` rises on the first cycle after `rst` is deasserted.
- Accept at cycle 0 (the edge ending the handshake). Cycle numbers below count from there.
- WRITE:
  - Shift cycles 1–8.
  - `cpu_load` in cycle 9.
  - `rsp_valid` in cycle 10, so latency is 10.
- READ:
  - `cpu_dump` in cycle 1.
  - Samples in cycles 2–9.
  - `rsp_valid` in cycle 10.
- STEP:
  - `cpu_step` in cycle 1.
  - Stop is first checked in cycle 2.
  - `rsp_valid` 1 cycle after stop is sampled.
- NOP, RUN and error responses: `rsp_valid` in cycle 1.
- Back-to-back commands: at most one every 2 cycles, because IDLE follows RESP.
- `rst` mid-command: abandon the command on the next edge.
  - No `rsp_valid` for it.
  - All port outputs go to 0.
  - A partial WRITE must not be followed by `cpu_load`.
- `req_valid` outside IDLE is ignored.

## Structure
- Package `spell_dbg_pkg`:
  - `cmd_t` enum with the encodings above.
  - `state_t` enum.
  - Register-select constants `SEL_PC`, `SEL_SP`, `SEL_OPCODE`, `SEL_TOS`.
- Sub-module `spell_dbg_shifter`:
  - 8-bit serializer/deserializer with a 3-bit bit counter.
  - Inputs: `start_tx`, `start_rx`, parallel data.
  - Outputs: `done` and the captured word.
  - The FSM in `spell_dbg_ctrl` instantiates it once.

## Test plan
- Reset, then WRITE sel=1 data=0xA5. `cpu_shift_in` is 1,0,1,0,0,1,0,1 in cycles 1–8, `cpu_load` is high in cycle 9, `cpu_reg_sel=1`, and `rsp_valid` is high in cycle 10 with err=0.
- READ sel=3 with a CPU model holding 0x3C. `cpu_dump` is high in cycle 1, and `rsp_data=0x3C` with `rsp_valid` in cycle 10. A following READ of 0x00 gives 0x00.
- RUN, then WRITE. `cpu_run=1` and the WRITE gets `rsp_err=1` in cycle 1 with no `cpu_load` and no shifting. A later HALT, with the CPU model raising stop after 5 cycles, gives err=0 and `cpu_run=0`.
- STEP with the stop model delayed 3 cycles gives err=0. STEP with stop never raised and `STEP_TIMEOUT=16` gives err=1 exactly 16 cycles into WAIT_STOP.
- `rst` asserted in cycle 5 of a WRITE: no `cpu_load` and no `rsp_valid` for it, and all outputs are 0 on the following cycle.
- Illegal `cmd=7` gives `rsp_err=1` in cycle 1 with no port activity. `req_valid` held high during a READ is not accepted until IDLE.
